// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier and the ALU it drives.
package mul_seq_ctrl_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned CNT_W_DEF = 7;
    localparam int unsigned ALU_OP_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu64.sv
// Shared combinational ALU; the multiplier borrows its adder through the alu_* ports.
module alu64
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_c_o
);

    always_comb begin
        result_c_o = '0;
        case (op_i)
            ALU_AND: result_c_o = a_i & b_i;
            ALU_OR:  result_c_o = a_i | b_i;
            ALU_ADD: result_c_o = a_i + b_i;
            ALU_SUB: result_c_o = a_i - b_i;
            ALU_NOR: result_c_o = ~(a_i | b_i);
            default: result_c_o = '0;
        endcase
    end

endmodule

// File: rtl/mul_seq_datapath.sv
// Accumulator, shifting multiplicand/multiplier and iteration counter for shift-add multiply.
module mul_seq_datapath
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] mcand_o,
    output logic            zero_o,
    output logic            last_c_o
);

    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             zero_q;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = alu_result_i;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b1;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            zero_q   <= (acc_d == '0);
        end
    end

    // Current step is the last one if the shifted multiplier runs out of ones or all bits are consumed.
    assign last_c_o = (mplier_q[XLEN-1:1] == '0) || (cnt_inc == CNT_W'(XLEN));
    assign acc_o    = acc_q;
    assign mcand_o  = mcand_q;
    assign zero_o   = zero_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: valid/ready handshake FSM steering the datapath through the shared ALU.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic [XLEN-1:0]     alu_a,
    output logic [XLEN-1:0]     alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     alu_result,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [XLEN-1:0]     product,
    output logic                product_zero,
    output logic                busy
);

    mul_state_e      state_q, state_d;
    logic            load, step, last_c;
    logic [XLEN-1:0] acc, mcand;
    logic            acc_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mul_seq_datapath #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .step_i       (step),
        .op_a_i       (op_a),
        .op_b_i       (op_b),
        .alu_result_i (alu_result),
        .acc_o        (acc),
        .mcand_o      (mcand),
        .zero_o       (acc_zero),
        .last_c_o     (last_c)
    );

    assign alu_a        = acc;
    assign alu_b        = mcand;
    assign alu_op       = ALU_ADD;
    assign product      = acc;
    assign product_zero = acc_zero;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and randomized checks of mul_seq_ctrl wired to the shared 64-bit ALU.
module tb_mul_seq_ctrl;
    import mul_seq_ctrl_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned BUDGET = 200;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_valid;
    logic            start_ready;
    logic [XLEN-1:0] op_a, op_b;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_op;
    logic            res_valid, res_ready;
    logic [XLEN-1:0] product;
    logic            product_zero;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .product      (product),
        .product_zero (product_zero),
        .busy         (busy)
    );

    alu64 #(.XLEN(XLEN)) u_alu (
        .op_i       (alu_op),
        .a_i        (alu_a),
        .b_i        (alu_b),
        .result_c_o (alu_result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept-to-res_valid latency: highest set bit of op_b plus two, two when op_b is zero.
    function automatic int exp_lat(input logic [63:0] b);
        int hb = -1;
        for (int i = 0; i < 64; i++) if (b[i]) hb = i;
        return (hb < 0) ? 2 : hb + 2;
    endfunction

    // One full transaction; holds res_ready low for 'stall' DONE cycles, optionally poking start_valid.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_p, input int stall, input bit poke);
        int lat;
        @(negedge clk);
        check_eq({tag, ".start_ready"}, start_ready, 1);
        op_a = a; op_b = b; start_valid = 1'b1; res_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_valid = 1'b0;
        for (int i = 0; i < BUDGET && !res_valid; i++) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check_eq({tag, ".res_valid"}, res_valid, 1);
        check_eq({tag, ".product"}, product, exp_p);
        check_eq({tag, ".zero"}, product_zero, (exp_p == 64'd0));
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat(b)));
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                start_valid = i[0];
                op_a = 64'd1000 + 64'(i);
                op_b = 64'd77;
            end
            @(posedge clk); @(negedge clk);
            check_eq({tag, ".hold_product"}, product, exp_p);
            check_eq({tag, ".hold_valid"}, res_valid, 1);
            check_eq({tag, ".hold_busy"}, busy, 1);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq({tag, ".idle_ready"}, start_ready, 1);
        check_eq({tag, ".idle_valid"}, res_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        reset = 1'b1; start_valid = 1'b0; res_ready = 1'b1; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst.start_ready", start_ready, 1);
        check_eq("rst.res_valid", res_valid, 0);
        check_eq("rst.busy", busy, 0);
        check_eq("rst.product", product, 0);
        check_eq("rst.product_zero", product_zero, 1);
        check_eq("rst.alu_op", alu_op, 4'b0010);

        do_op("mul3x5", 64'd3, 64'd5, 64'd15, 0, 1'b0);
        do_op("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1'b0);
        do_op("opb_zero", 64'd12345, 64'd0, 64'd0, 0, 1'b0);
        do_op("stall7x6", 64'd7, 64'd6, 64'd42, 10, 1'b1);
        do_op("neg_x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1, 1'b0);
        do_op("ovf", 64'h8000_0000_0000_0001, 64'd2, 64'd2, 0, 1'b0);

        // Abort mid-run with reset: no result may appear afterwards.
        @(negedge clk);
        op_a = 64'd9; op_b = 64'h8000_0000_0000_0000; start_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start_valid = 1'b0;
        check_eq("abort.busy_run", busy, 1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check_eq("abort.still_run", res_valid, 0);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        check_eq("abort.idle_ready", start_ready, 1);
        check_eq("abort.busy", busy, 0);
        check_eq("abort.product", product, 0);
        check_eq("abort.zero", product_zero, 1);
        begin
            int seen = 0;
            for (int i = 0; i < 70; i++) begin
                @(posedge clk); @(negedge clk);
                if (res_valid) seen++;
            end
            check_eq("abort.no_valid", 64'(seen), 0);
        end
        do_op("after_abort", 64'd2, 64'd3, 64'd6, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            do_op("rand", a, b, a * b, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter XLEN, default 64, operand/result width.
REQ-002 Parameter CNT_W, default 7, iteration counter width (holds 0..XLEN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  requester presents operands.
REQ-006 start_ready  output  1  block accepts operands (high only in IDLE).
REQ-007 op_a  input  XLEN  multiplicand, sampled on accept.
REQ-008 op_b  input  XLEN  multiplier, sampled on accept.
REQ-009 alu_a  output  XLEN  ALU operand a (accumulator).
REQ-010 alu_b  output  XLEN  ALU operand b (shifted multiplicand).
REQ-011 alu_op  output  4  ALU operation select; constant 4'b0010 (add).
REQ-012 alu_result  input  XLEN  combinational ALU sum, consumed same cycle.
REQ-013 res_valid  output  1  product available.
REQ-014 res_ready  input  1  consumer takes product.
REQ-015 product  output  XLEN  low XLEN bits of op_a*op_b (RISC-V MUL semantics).
REQ-016 product_zero  output  1  product == 0.
REQ-017 busy  output  1  high in RUN or DONE.

Function
REQ-018 States SHALL be IDLE, RUN, DONE; encoding from shared package.
REQ-019 IDLE: start_ready=1; accept when start_valid&start_ready; load acc=0, mcand=op_a, mplier=op_b, cnt=0; go RUN.
REQ-020 RUN, per cycle: if mplier[0]=1, acc <= alu_result; mcand <= mcand<<1 (zero fill, MSB discarded); mplier <= mplier>>1 (logical); cnt <= cnt+1.
REQ-021 alu_a SHALL equal acc and alu_b mcand in every state; sum overflow beyond XLEN discarded (modulo 2^XLEN).
REQ-022 RUN->DONE when, after the update, mplier==0 or cnt==XLEN; early termination required.
REQ-023 Latency accept->res_valid: (index of highest set bit of op_b)+2 cycles; op_b=0 gives 2 cycles (one RUN cycle, no add); max XLEN+1.
REQ-024 DONE: res_valid=1, product=acc, product_zero=(acc==0); held stable until res_ready.
REQ-025 DONE with res_ready=1 -> IDLE next cycle; no same-cycle re-accept (start_ready low in DONE).
REQ-026 start_valid in RUN/DONE SHALL be ignored; operands not resampled.
REQ-027 res_ready outside DONE SHALL have no effect.
REQ-028 Signed operands need no special handling: low XLEN bits are sign-agnostic.

Reset
REQ-029 reset SHALL force IDLE, acc=0, mcand=0, mplier=0, cnt=0 on next edge, taking priority over all other inputs.
REQ-030 After reset: start_ready=1, res_valid=0, busy=0, product=0, product_zero=1, alu_op=4'b0010.
REQ-031 reset asserted in RUN or DONE SHALL abort the operation; no res_valid for the aborted product.

Structure
REQ-032 Shared package SHALL hold state enum (IDLE/RUN/DONE) and ALU opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100).
REQ-033 Block contains no adder; the sum comes through alu_* ports from the existing 64-bit ALU.
REQ-034 One sub-module natural: mul_seq_datapath (acc/mcand/mplier/cnt registers and shifts), FSM in top.
REQ-035 Testbench SHALL instantiate the team's 64-bit ALU and wire alu_* ports to it.

Verification
REQ-036 op_a=3, op_b=5, res_ready=1 -> product=15, product_zero=0, res_valid 4 cycles after accept.
REQ-037 op_a=64'hFFFF_FFFF_FFFF_FFFF, op_b=64'hFFFF_FFFF_FFFF_FFFF -> product=1, RUN lasts 64 cycles.
REQ-038 op_a=12345, op_b=0 -> product=0, product_zero=1, res_valid 2 cycles after accept.
REQ-039 op_a=7, op_b=6, res_ready held low 10 cycles -> product=42 stable, res_valid high throughout, start_valid pulses ignored.
REQ-040 Accept op_a=9, op_b=64'h8000_0000_0000_0000, assert reset after 20 RUN cycles -> IDLE next edge, no res_valid; new op_a=2, op_b=3 -> product=6.
REQ-041 1000 random operand pairs with random res_ready stalls -> product equals (op_a*op_b) mod 2^64 each time.
